// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq : sequential radix-2 shift-add multiplier feeding the HiLo register.
//
// Accepts one request at a time: MULT (signed) or MADDU (unsigned, HiLo
// accumulates). Each CALC cycle consumes one multiplier bit. When the product
// is ready it is registered on MultAns, and Signal pulses OUT for one cycle.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    request strobe, sampled when the engine is free
//   Funct    6'b011001 = MULT, 6'b000001 = MADDU; other codes are ignored
//   dataA    multiplicand
//   dataB    multiplier
//   MultAns  registered 2*WIDTH-bit product, held until the next completion
//   Signal   6'b111111 during the DONE cycle, 6'b000000 otherwise
//   add      1 during the DONE cycle of a MADDU (HiLo accumulates)
//   busy     1 whenever the state is not IDLE
//
// Build option
//   MULT_EARLY_EXIT_EN : when defined, CALC ends as soon as the remaining
//                        multiplier is zero (minimum one step). Results are
//                        unchanged; only latency shrinks.
// -----------------------------------------------------------------------------
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           Funct,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic [2*WIDTH-1:0]   MultAns,
    output logic [5:0]           Signal,
    output logic                 add,
    output logic                 busy
);

    localparam int          PROD_W      = 2 * WIDTH;
    localparam int          CNT_W       = $clog2(WIDTH);
    localparam logic [5:0]  FUNCT_MULT  = 6'b011001;
    localparam logic [5:0]  FUNCT_MADDU = 6'b000001;
    localparam logic [5:0]  SIG_OUT     = 6'b111111;
    localparam logic [5:0]  SIG_NONE    = 6'b000000;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [PROD_W-1:0] mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PROD_W-1:0] acc;
    logic [CNT_W-1:0]  stepCnt;
    logic              sign;
    logic              opMaddu;

    logic              isMult;
    logic              isMaddu;
    logic              accept;
    logic              lastStep;
    logic              finish;
    logic [PROD_W-1:0] stepSum;
    logic [WIDTH-1:0]  mplierShift;
    logic [WIDTH-1:0]  magA;
    logic [WIDTH-1:0]  magB;

    // Unsigned magnitude of a signed operand; the most negative value maps to
    // itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] absMag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    // Two's-complement negation of the full-width product, modulo 2^PROD_W.
    function automatic logic [PROD_W-1:0] negProd(input logic [PROD_W-1:0] v);
        return ~v + PROD_W'(1);
    endfunction

    always_comb begin
        isMult      = (Funct == FUNCT_MULT);
        isMaddu     = (Funct == FUNCT_MADDU);
        magA        = isMult ? absMag($signed(dataA)) : dataA;
        magB        = isMult ? absMag($signed(dataB)) : dataB;
        stepSum     = acc + (mplier[0] ? mcand : '0);
        mplierShift = mplier >> 1;
`ifdef MULT_EARLY_EXIT_EN
        lastStep    = (stepCnt == LAST_STEP) || (mplierShift == '0);
`else
        lastStep    = (stepCnt == LAST_STEP);
`endif
        // The DONE cycle's closing edge is also the first edge at which a
        // new request can be taken, so DONE accepts like IDLE does.
        accept      = start && (isMult || isMaddu) && ((state == IDLE) || (state == DONE));
        finish      = (state == CALC) && lastStep;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = CALC;
            CALC:    if (lastStep) stateNext = DONE;
            DONE:    stateNext = accept ? CALC : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            stepCnt <= '0;
            sign    <= 1'b0;
            opMaddu <= 1'b0;
            MultAns <= '0;
            Signal  <= SIG_NONE;
            add     <= 1'b0;
        end else begin
            if (accept) begin
                mcand   <= {{WIDTH{1'b0}}, magA};
                mplier  <= magB;
                acc     <= '0;
                stepCnt <= '0;
                sign    <= isMult && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                opMaddu <= isMaddu;
            end else if (state == CALC) begin
                acc     <= stepSum;
                mplier  <= mplierShift;
                mcand   <= mcand << 1;
                stepCnt <= stepCnt + CNT_W'(1);
            end

            // The final step's sum goes straight to the output register, so
            // the result is visible during the DONE cycle itself.
            if (finish) begin
                MultAns <= sign ? negProd(stepSum) : stepSum;
                Signal  <= SIG_OUT;
                add     <= opMaddu;
            end else begin
                Signal  <= SIG_NONE;
                add     <= 1'b0;
            end
        end
    end

endmodule
